// File: rtl/wb_cmd_master_pkg.sv
// Shared definitions for the Wishbone command master and its benches.
package wb_cmd_master_pkg;

  // FSM state encoding
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } wbm_state_t;

  // Width of the ack timeout counter
  localparam int unsigned TIMER_W = 16;

  // Bus and command widths
  localparam int unsigned ADR_W = 32;
  localparam int unsigned DAT_W = 32;
  localparam int unsigned SEL_W = 4;

  // Peripheral register map used by the IO block and by benches
  localparam logic [ADR_W-1:0] LED_ADR = 32'h0000_0000;
  localparam logic [ADR_W-1:0] SW_ADR  = 32'h0000_0004;

endpackage

// File: rtl/wb_cmd_master.sv
// Wishbone classic single-transfer master: one command in, one bus cycle out,
// one response (read data or timeout error) back.
module wb_cmd_master
  import wb_cmd_master_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             reset,
  // command port
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_we,
  input  logic [ADR_W-1:0] cmd_adr,
  input  logic [SEL_W-1:0] cmd_sel,
  input  logic [DAT_W-1:0] cmd_dat,
  // response port
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [DAT_W-1:0] rsp_dat,
  output logic             rsp_err,
  output logic             busy,
  // Wishbone master side
  output logic             wb_cyc_o,
  output logic             wb_stb_o,
  output logic             wb_we_o,
  output logic [ADR_W-1:0] wb_adr_o,
  output logic [SEL_W-1:0] wb_sel_o,
  output logic [DAT_W-1:0] wb_dat_o,
  input  logic [DAT_W-1:0] wb_dat_i,
  input  logic             wb_ack_i
);

  // Last timer value before the transfer is abandoned
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT - 1);

  wbm_state_t         state;
  logic [TIMER_W-1:0] timer;

  // Handshake flags decoded straight from the state
  assign cmd_ready = (state == IDLE);
  assign busy      = (state != IDLE);

  // Transfer FSM with registered bus and response outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      timer     <= '0;
      wb_cyc_o  <= 1'b0;
      wb_stb_o  <= 1'b0;
      wb_we_o   <= 1'b0;
      wb_adr_o  <= '0;
      wb_sel_o  <= '0;
      wb_dat_o  <= '0;
      rsp_valid <= 1'b0;
      rsp_dat   <= '0;
      rsp_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            wb_we_o  <= cmd_we;
            wb_adr_o <= cmd_adr;
            wb_sel_o <= cmd_sel;
            wb_dat_o <= cmd_dat;
            wb_cyc_o <= 1'b1;
            wb_stb_o <= 1'b1;
            timer    <= '0;
            state    <= BUS;
          end
        end
        BUS: begin
          // ack has priority over a timeout on the same edge
          if (wb_ack_i) begin
            rsp_dat   <= wb_we_o ? '0 : wb_dat_i;
            rsp_err   <= 1'b0;
            rsp_valid <= 1'b1;
            wb_cyc_o  <= 1'b0;
            wb_stb_o  <= 1'b0;
            state     <= RESP;
          end else if (timer == TIMER_LAST) begin
            rsp_dat   <= '0;
            rsp_err   <= 1'b1;
            rsp_valid <= 1'b1;
            wb_cyc_o  <= 1'b0;
            wb_stb_o  <= 1'b0;
            state     <= RESP;
          end else begin
            timer <= timer + TIMER_W'(1);
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          wb_cyc_o  <= 1'b0;
          wb_stb_o  <= 1'b0;
          rsp_valid <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wb_cmd_master.sv
// Directed bench for wb_cmd_master with a small LED/switch Wishbone responder.
module tb_wb_cmd_master;
  import wb_cmd_master_pkg::*;

  localparam int unsigned TO = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid, cmd_ready, cmd_we;
  logic [31:0] cmd_adr, cmd_dat;
  logic [3:0]  cmd_sel;
  logic        rsp_valid, rsp_ready, rsp_err, busy;
  logic [31:0] rsp_dat;
  logic        wb_cyc_o, wb_stb_o, wb_we_o;
  logic [31:0] wb_adr_o, wb_dat_o;
  logic [3:0]  wb_sel_o;
  logic [31:0] wb_dat_i;
  logic        wb_ack_i;

  int n_cmp = 0;
  int n_bad = 0;

  wb_cmd_master #(.TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
    .cmd_adr(cmd_adr), .cmd_sel(cmd_sel), .cmd_dat(cmd_dat),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_dat(rsp_dat),
    .rsp_err(rsp_err), .busy(busy),
    .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o),
    .wb_adr_o(wb_adr_o), .wb_sel_o(wb_sel_o), .wb_dat_o(wb_dat_o),
    .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i)
  );

  always #5 clk = ~clk;

  // Responder: registered ack after ack_delay stb edges; LED reg RW, switch reg RO
  logic        ack_en    = 1'b1;
  int          ack_delay = 0;
  int          s_cnt     = 0;
  logic        s_ack     = 1'b0;
  logic [31:0] s_dat     = '0;
  logic [31:0] led_reg   = '0;
  logic [31:0] sw_reg    = 32'h0000_003C;

  assign wb_ack_i = s_ack;
  assign wb_dat_i = s_dat;

  always @(posedge clk) begin
    if (wb_cyc_o && wb_stb_o && !s_ack) begin
      if (ack_en && s_cnt == ack_delay) begin
        s_ack <= 1'b1;
        s_cnt <= 0;
        if (wb_we_o) begin
          if (wb_adr_o == LED_ADR)
            for (int b = 0; b < 4; b++)
              if (wb_sel_o[b]) led_reg[b*8 +: 8] <= wb_dat_o[b*8 +: 8];
        end else begin
          s_dat <= (wb_adr_o == SW_ADR)  ? sw_reg :
                   (wb_adr_o == LED_ADR) ? led_reg : 32'hDEAD_BEEF;
        end
      end else begin
        s_cnt <= s_cnt + 1;
      end
    end else begin
      s_ack <= 1'b0;
      if (!wb_stb_o) s_cnt <= 0;
    end
  end

  // Single comparison point for the whole bench
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Issue one command, measure stb length, collect the response and consume it
  task automatic run_cmd(input string tag, input logic we, input logic [31:0] adr,
                         input logic [3:0] sel, input logic [31:0] dat,
                         output int stb_cyc, output logic [31:0] rdat, output logic rerr);
    int   n;
    logic we_bad;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_we = we; cmd_adr = adr; cmd_sel = sel; cmd_dat = dat;
    @(negedge clk);
    cmd_valid = 1'b0;
    check({tag, "_adr"}, wb_adr_o, adr);
    check({tag, "_sel"}, {28'd0, wb_sel_o}, {28'd0, sel});
    stb_cyc = 0; n = 0; we_bad = 1'b0;
    while (!rsp_valid && n < 400) begin
      if (wb_stb_o) begin
        stb_cyc++;
        if (wb_we_o !== we || wb_cyc_o !== wb_stb_o) we_bad = 1'b1;
      end
      @(negedge clk);
      n++;
    end
    check({tag, "_rsp_seen"}, {31'd0, rsp_valid}, 32'd1);
    check({tag, "_ctl_stable"}, {31'd0, we_bad}, 32'd0);
    check({tag, "_stb_low_at_rsp"}, {31'd0, wb_stb_o}, 32'd0);
    rdat = rsp_dat; rerr = rsp_err;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check({tag, "_idle_ready"}, {30'd0, cmd_ready, busy}, 32'd2);
  endtask

  int          sc;
  logic [31:0] rd;
  logic        re;
  logic [31:0] held_dat;
  logic        held_err;
  int          n;
  logic        seen;

  initial begin
    reset = 1'b1; cmd_valid = 1'b0; cmd_we = 1'b0; cmd_adr = '0; cmd_sel = '0;
    cmd_dat = '0; rsp_ready = 1'b0;
    repeat (2) @(negedge clk);
    // Reset state
    check("rst_cyc_stb_we", {29'd0, wb_cyc_o, wb_stb_o, wb_we_o}, 32'd0);
    check("rst_adr", wb_adr_o, 32'd0);
    check("rst_dat_sel", wb_dat_o | {28'd0, wb_sel_o}, 32'd0);
    check("rst_rsp", {30'd0, rsp_valid, rsp_err}, 32'd0);
    check("rst_rsp_dat", rsp_dat, 32'd0);
    check("rst_ready_busy", {30'd0, cmd_ready, busy}, 32'd2);
    reset = 1'b0;

    // Write to LED register, zero-wait responder
    ack_en = 1'b1; ack_delay = 0;
    run_cmd("wr", 1'b1, LED_ADR, 4'hF, 32'h0000_00A5, sc, rd, re);
    check("wr_stb_cycles", 32'(sc), 32'd2);
    check("wr_rsp_dat", rd, 32'd0);
    check("wr_rsp_err", {31'd0, re}, 32'd0);
    check("wr_led_reg", led_reg, 32'h0000_00A5);

    // Read switch register
    run_cmd("rd", 1'b0, SW_ADR, 4'hF, 32'h1234_5678, sc, rd, re);
    check("rd_stb_cycles", 32'(sc), 32'd2);
    check("rd_rsp_dat", rd, 32'h0000_003C);
    check("rd_rsp_err", {31'd0, re}, 32'd0);

    // Partial-lane write then read back the LED register
    run_cmd("wr2", 1'b1, LED_ADR, 4'h2, 32'h0000_7700, sc, rd, re);
    run_cmd("rd2", 1'b0, LED_ADR, 4'hF, 32'd0, sc, rd, re);
    check("rd2_rsp_dat", rd, 32'h0000_77A5);

    // Timeout: slave never acks
    ack_en = 1'b0;
    run_cmd("to", 1'b0, SW_ADR, 4'hF, 32'd0, sc, rd, re);
    check("to_stb_cycles", 32'(sc), 32'(TO));
    check("to_rsp_dat", rd, 32'd0);
    check("to_rsp_err", {31'd0, re}, 32'd1);
    ack_en = 1'b1;
    run_cmd("after_to", 1'b0, SW_ADR, 4'hF, 32'd0, sc, rd, re);
    check("after_to_dat", rd, 32'h0000_003C);
    check("after_to_err", {31'd0, re}, 32'd0);

    // Ack sampled on the same edge that would time out
    ack_delay = int'(TO) - 2;
    run_cmd("edge", 1'b0, SW_ADR, 4'hF, 32'd0, sc, rd, re);
    check("edge_stb_cycles", 32'(sc), 32'(TO));
    check("edge_rsp_dat", rd, 32'h0000_003C);
    check("edge_rsp_err", {31'd0, re}, 32'd0);
    ack_delay = 0;

    // Back-pressure with a second command waiting
    @(negedge clk);
    cmd_valid = 1'b1; cmd_we = 1'b0; cmd_adr = SW_ADR; cmd_sel = 4'hF;
    @(negedge clk);
    cmd_valid = 1'b0;
    n = 0;
    while (!rsp_valid && n < 50) begin @(negedge clk); n++; end
    check("bp_rsp_seen", {31'd0, rsp_valid}, 32'd1);
    held_dat = 32'h0000_003C; held_err = 1'b0;
    cmd_valid = 1'b1; cmd_we = 1'b1; cmd_adr = 32'h0000_0010; cmd_sel = 4'h3;
    cmd_dat = 32'hCAFE_0001;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_rsp_dat", rsp_dat, held_dat);
      check("bp_rsp_err_valid", {30'd0, rsp_err, rsp_valid}, {30'd0, held_err, 1'b1});
      check("bp_ready_stb", {30'd0, cmd_ready, wb_stb_o}, 32'd0);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check("bp_back_idle", {29'd0, rsp_valid, cmd_ready, wb_stb_o}, 32'd2);
    @(negedge clk);
    cmd_valid = 1'b0;
    check("bp_accept_stb", {30'd0, wb_stb_o, wb_we_o}, 32'd3);
    check("bp_accept_adr", wb_adr_o, 32'h0000_0010);
    n = 0;
    while (!rsp_valid && n < 50) begin @(negedge clk); n++; end
    check("bp2_rsp", {30'd0, rsp_valid, rsp_err}, 32'd2);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;

    // Reset during the second stb cycle
    ack_delay = 3;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_we = 1'b0; cmd_adr = SW_ADR; cmd_sel = 4'hF;
    @(negedge clk);
    cmd_valid = 1'b0;
    check("mr_stb1", {31'd0, wb_stb_o}, 32'd1);
    @(negedge clk);
    check("mr_stb2", {31'd0, wb_stb_o}, 32'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("mr_cyc_stb", {30'd0, wb_cyc_o, wb_stb_o}, 32'd0);
    check("mr_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("mr_ready_busy", {30'd0, cmd_ready, busy}, 32'd2);
    seen = 1'b0;
    rsp_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (rsp_valid || wb_stb_o) seen = 1'b1;
    end
    rsp_ready = 1'b0;
    check("mr_no_activity", {31'd0, seen}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Absolute time bound
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
